// File: rtl/divider_pkg.sv
// Shared types for the restoring divider and its downstream result collector.
package divider_pkg;

    localparam int RESULT_W = 6;
    localparam int STATS_W  = 8;

    typedef enum logic {
        IDLE,
        GET_Q
    } div_state_t;

    typedef struct packed {
        logic [RESULT_W-1:0] quot;
        logic [RESULT_W-1:0] rem;
        logic                ovf;
        logic                dz;
    } div_entry_t;

endpackage

// File: rtl/div_result_fifo.sv
// Small power-of-two FIFO holding assembled divider results; a full FIFO still
// accepts a push when the head is popped in the same cycle.
module div_result_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = divider_pkg::div_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t din,
    output logic   full,
    input  logic   pop,
    output logic   empty,
    output entry_t head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    entry_t        mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: storage is cleared too, so the head fields read as zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/div_result_collector.sv
// Collects the divider's remainder/quotient beats into one entry and buffers it.
// Optional DIV_COLLECTOR_STATS_EN adds saturating pushed/dropped counters.
module div_result_collector
    import divider_pkg::*;
#(
    parameter int W     = RESULT_W,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         div_done,
    input  logic [W-1:0] div_result,
    input  logic         div_ovf,
    input  logic         div_dz,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_quot,
    output logic [W-1:0] out_rem,
    output logic         out_ovf,
    output logic         out_dz,
    output logic         busy,
    output logic         lost,
    output logic         proto_err
`ifdef DIV_COLLECTOR_STATS_EN
    ,
    output logic [STATS_W-1:0] res_cnt,
    output logic [STATS_W-1:0] drop_cnt
`endif
);

    // Same layout as div_entry_t, sized by W.
    typedef struct packed {
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        logic         ovf;
        logic         dz;
    } entry_t;

    div_state_t   state;
    div_state_t   next_state;
    logic [W-1:0] rem_q;
    logic         ovf_q;
    logic         dz_q;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    entry_t       push_entry;
    entry_t       head;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        next_state = state;
        push       = 1'b0;
        case (state)
            IDLE:    if (div_done) next_state = GET_Q;
            GET_Q: begin
                next_state = IDLE;
                push       = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q <= '0;
            ovf_q <= 1'b0;
            dz_q  <= 1'b0;
        end else if (state == IDLE && div_done) begin
            rem_q <= div_result;
            ovf_q <= div_ovf;
            dz_q  <= div_dz;
        end
    end

    // An overflowed division carries no meaningful quotient or remainder.
    always_comb begin
        push_entry.quot = ovf_q ? '0 : div_result;
        push_entry.rem  = ovf_q ? '0 : rem_q;
        push_entry.ovf  = ovf_q;
        push_entry.dz   = dz_q;
    end

    assign pop = out_valid & out_ready;

    div_result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .full  (full),
        .pop   (pop),
        .empty (empty),
        .head  (head)
    );

    assign out_valid = ~empty;
    assign out_quot  = head.quot;
    assign out_rem   = head.rem;
    assign out_ovf   = head.ovf;
    assign out_dz    = head.dz;
    assign busy      = (state == GET_Q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            lost      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (push && full && !pop)         lost      <= 1'b1;
            if (state == GET_Q && div_done)   proto_err <= 1'b1;
        end
    end

`ifdef DIV_COLLECTOR_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_cnt  <= '0;
            drop_cnt <= '0;
        end else if (push) begin
            if (!full || pop) begin
                if (res_cnt != '1) res_cnt <= res_cnt + STATS_W'(1);
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + STATS_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_div_result_collector.sv
// Bench for div_result_collector: directed vectors, corner sequences and a
// randomized run against a queue-based model of the collector.
module tb_div_result_collector;

    localparam int W     = 6;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         div_done;
    logic [W-1:0] div_result;
    logic         div_ovf;
    logic         div_dz;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quot;
    logic [W-1:0] out_rem;
    logic         out_ovf;
    logic         out_dz;
    logic         busy;
    logic         lost;
    logic         proto_err;
`ifdef DIV_COLLECTOR_STATS_EN
    logic [7:0]   res_cnt;
    logic [7:0]   drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    div_result_collector #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_done   (div_done),
        .div_result (div_result),
        .div_ovf    (div_ovf),
        .div_dz     (div_dz),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_quot   (out_quot),
        .out_rem    (out_rem),
        .out_ovf    (out_ovf),
        .out_dz     (out_dz),
        .busy       (busy),
        .lost       (lost),
        .proto_err  (proto_err)
`ifdef DIV_COLLECTOR_STATS_EN
        ,
        .res_cnt    (res_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] rem_bus;
        logic [W-1:0] quot_bus;
        logic         ovf;
        logic         dz;
        logic [W-1:0] exp_quot;
        logic [W-1:0] exp_rem;
        logic         exp_ovf;
        logic         exp_dz;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        logic         ovf;
        logic         dz;
    } ent_t;

    vec_t vecs [4];
    ent_t mq [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_head(input string name, input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic o, input logic d);
        check({name, "_valid"}, 32'(out_valid), 32'(1));
        check({name, "_quot"},  32'(out_quot),  32'(q));
        check({name, "_rem"},   32'(out_rem),   32'(r));
        check({name, "_ovf"},   32'(out_ovf),   32'(o));
        check({name, "_dz"},    32'(out_dz),    32'(d));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        div_done = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Remainder beat with done, then quotient beat with junk flags; returns at T+2.
    task automatic send(input logic [W-1:0] r, input logic [W-1:0] q, input logic o, input logic d);
        div_done   = 1'b1;
        div_result = r;
        div_ovf    = o;
        div_dz     = d;
        tick();
        check("busy_t1", 32'(busy), 32'(1));
        div_done   = 1'b0;
        div_result = q;
        div_ovf    = 1'($urandom);
        div_dz     = 1'($urandom);
        tick();
        div_result = W'($urandom);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic         m_pending;
    logic [W-1:0] m_rem;
    logic         m_ovf;
    logic         m_dz;
    logic         m_lost;
    int           m_res;
    int           m_drop;

    initial begin
        vecs[0] = '{6'd9,  6'd3,  1'b0, 1'b0, 6'd3, 6'd9, 1'b0, 1'b0};
        vecs[1] = '{6'd0,  6'd6,  1'b0, 1'b0, 6'd6, 6'd0, 1'b0, 1'b0};
        vecs[2] = '{6'd37, 6'd55, 1'b1, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0};
        vecs[3] = '{6'd12, 6'd63, 1'b1, 1'b1, 6'd0, 6'd0, 1'b1, 1'b1};

        rst = 1'b0;
        div_done = 1'b0;
        div_result = '1;
        div_ovf = 1'b0;
        div_dz = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_busy",  32'(busy),      32'(0));
        check("rst_lost",  32'(lost),      32'(0));
        check("rst_proto", 32'(proto_err), 32'(0));
        check("rst_quot",  32'(out_quot),  32'(0));
        check("rst_rem",   32'(out_rem),   32'(0));
        check("rst_ovf",   32'(out_ovf),   32'(0));
        check("rst_dz",    32'(out_dz),    32'(0));
`ifdef DIV_COLLECTOR_STATS_EN
        check("rst_res_cnt",  32'(res_cnt),  32'(0));
        check("rst_drop_cnt", 32'(drop_cnt), 32'(0));
`endif
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            send(vecs[i].rem_bus, vecs[i].quot_bus, vecs[i].ovf, vecs[i].dz);
            check_head($sformatf("vec%0d", i), vecs[i].exp_quot, vecs[i].exp_rem,
                       vecs[i].exp_ovf, vecs[i].exp_dz);
            pop_one();
            check($sformatf("vec%0d_drained", i), 32'(out_valid), 32'(0));
        end

        // Back-to-back: second done at T+2 of the first result.
        send(6'd0, 6'd6, 1'b0, 1'b0);
        check("b2b_first_valid", 32'(out_valid), 32'(1));
        send(6'd9, 6'd3, 1'b0, 1'b0);
        check_head("b2b_e0", 6'd6, 6'd0, 1'b0, 1'b0);
        pop_one();
        check_head("b2b_e1", 6'd3, 6'd9, 1'b0, 1'b0);
        pop_one();
        check("b2b_empty", 32'(out_valid), 32'(0));
        check("b2b_lost",  32'(lost),      32'(0));

        // Three results into a full FIFO with no consumer.
        do_reset();
        send(6'd1, 6'd2, 1'b0, 1'b0);
        send(6'd3, 6'd4, 1'b0, 1'b0);
        send(6'd5, 6'd6, 1'b0, 1'b0);
        check("bp_lost", 32'(lost), 32'(1));
`ifdef DIV_COLLECTOR_STATS_EN
        check("bp_drop_cnt", 32'(drop_cnt), 32'(1));
        check("bp_res_cnt",  32'(res_cnt),  32'(2));
`endif
        check_head("bp_e0", 6'd2, 6'd1, 1'b0, 1'b0);
        pop_one();
        check_head("bp_e1", 6'd4, 6'd3, 1'b0, 1'b0);
        pop_one();
        check("bp_empty", 32'(out_valid), 32'(0));

        // Same, but the head is popped in the very cycle the third entry is pushed.
        do_reset();
        send(6'd1, 6'd2, 1'b0, 1'b0);
        send(6'd3, 6'd4, 1'b0, 1'b0);
        div_done = 1'b1;
        div_result = 6'd5;
        div_ovf = 1'b0;
        div_dz = 1'b0;
        tick();
        div_done = 1'b0;
        div_result = 6'd6;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bpr_lost", 32'(lost), 32'(0));
`ifdef DIV_COLLECTOR_STATS_EN
        check("bpr_drop_cnt", 32'(drop_cnt), 32'(0));
        check("bpr_res_cnt",  32'(res_cnt),  32'(3));
`endif
        check_head("bpr_e1", 6'd4, 6'd3, 1'b0, 1'b0);
        pop_one();
        check_head("bpr_e2", 6'd6, 6'd5, 1'b0, 1'b0);

        // Reset during the quotient beat with an entry still queued.
        div_done = 1'b1;
        div_result = 6'd20;
        tick();
        div_done = 1'b0;
        div_result = 6'd33;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_busy",  32'(busy),      32'(0));
        check("midrst_valid", 32'(out_valid), 32'(0));
        check("midrst_quot",  32'(out_quot),  32'(0));
        check("midrst_rem",   32'(out_rem),   32'(0));
        check("midrst_ovf",   32'(out_ovf),   32'(0));
        check("midrst_dz",    32'(out_dz),    32'(0));
        check("midrst_lost",  32'(lost),      32'(0));
        tick();
        check("midrst_nopush", 32'(out_valid), 32'(0));

        // done repeated on the quotient beat.
        div_done = 1'b1;
        div_result = 6'd5;
        tick();
        div_done = 1'b1;
        div_result = 6'd7;
        tick();
        div_done = 1'b0;
        check("proto_err", 32'(proto_err), 32'(1));
        check("proto_busy", 32'(busy), 32'(0));
        check_head("proto_entry", 6'd7, 6'd5, 1'b0, 1'b0);

        // Randomized run against the queue model.
        do_reset();
        mq.delete();
        m_pending = 1'b0;
        m_rem = '0;
        m_ovf = 1'b0;
        m_dz = 1'b0;
        m_lost = 1'b0;
        m_res = 0;
        m_drop = 0;
        for (int c = 0; c < 800; c++) begin
            int   sz;
            logic do_pop;
            ent_t e;
            div_result = W'($urandom);
            if (m_pending) begin
                div_done = 1'b0;
                div_ovf  = 1'($urandom);
                div_dz   = 1'($urandom);
            end else begin
                div_done = 1'($urandom_range(0, 1));
                div_ovf  = ($urandom_range(0, 3) == 0);
                div_dz   = div_ovf & 1'($urandom);
            end
            out_ready = 1'($urandom);

            check("rnd_valid", 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                check_head("rnd_head", mq[0].quot, mq[0].rem, mq[0].ovf, mq[0].dz);
            end
            check("rnd_busy", 32'(busy), 32'(m_pending));
            check("rnd_lost", 32'(lost), 32'(m_lost));
`ifdef DIV_COLLECTOR_STATS_EN
            check("rnd_res_cnt",  32'(res_cnt),  32'((m_res > 255) ? 255 : m_res));
            check("rnd_drop_cnt", 32'(drop_cnt), 32'((m_drop > 255) ? 255 : m_drop));
`endif

            sz = mq.size();
            do_pop = (sz != 0) && out_ready;
            e.ovf  = m_ovf;
            e.dz   = m_dz;
            e.quot = m_ovf ? '0 : div_result;
            e.rem  = m_ovf ? '0 : m_rem;
            if (do_pop) void'(mq.pop_front());
            if (m_pending) begin
                if (sz == DEPTH && !do_pop) begin
                    m_lost = 1'b1;
                    m_drop++;
                end else begin
                    mq.push_back(e);
                    m_res++;
                end
                m_pending = 1'b0;
            end else if (div_done) begin
                m_pending = 1'b1;
                m_rem = div_result;
                m_ovf = div_ovf;
                m_dz  = div_dz;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
